regfile_dump_sequencer: RTL

REGFILE_DUMP_SEQUENCER -- requirements
Module: regfile_dump_sequencer

---
 rtl/regfile_dump_sequencer_if.sv | 25 ++
 rtl/regfile_dump_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/regfile_dump_sequencer_if.sv
// Purpose: groups the start/abort control, register-file read port and the
//          byte stream toward the UART into one bundle.
// Ports:   master = sequencer side (drives rd_addr, tx_*, busy, done);
//          slave  = environment side (drives start, abort, rd_data, tx_ready).
interface regfile_dump_sequencer_if;
  logic        start;
  logic        abort;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  modport master (
    input  start, abort, rd_data, tx_ready,
    output rd_addr, tx_data, tx_valid, busy, done
  );

  modport slave (
    output start, abort, rd_data, tx_ready,
    input  rd_addr, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/regfile_dump_sequencer.sv
// Purpose: dumps NUM_REGS 32-bit registers as a byte frame
//          (HEADER, data bytes little-endian, XOR checksum) toward a UART.
// Latency: first byte valid one cycle after start; one LOAD bubble per register.
// Backpressure: tx_valid/tx_data held until tx_ready; abort/reset drop the frame.
// Ports:   clk, reset (async, active-high); bus = regfile_dump_sequencer_if.master
//          carrying start/abort, rd_addr/rd_data, tx_data/tx_valid/tx_ready,
//          busy and the one-cycle done pulse.
module regfile_dump_sequencer #(
  parameter int         NUM_REGS = 32,
  parameter logic [7:0] HEADER   = 8'hA5
) (
  input logic                        clk,
  input logic                        reset,
  regfile_dump_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_t      state_q;
  logic [4:0]  idx_q;
  logic [1:0]  cnt_q;
  logic [31:0] shadow_q;
  logic [7:0]  csum_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic [4:0]  rd_addr_q;
  logic        busy_q;
  logic        done_q;

  // Derived next values used by the state machine.
  logic        xfer_d;
  logic [7:0]  csum_d;
  logic [1:0]  cnt_inc_d;
  logic [4:0]  byte_base_d;
  logic [7:0]  next_byte_d;

  assign xfer_d      = tx_valid_q & bus.tx_ready;
  // Checksum folds in the byte being transferred this cycle.
  assign csum_d      = csum_q ^ tx_data_q;
  assign cnt_inc_d   = cnt_q + 2'd1;
  assign byte_base_d = {cnt_inc_d, 3'b000};
  // Bytes after the first come from the shadow, never from live rd_data.
  assign next_byte_d = shadow_q[byte_base_d +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= 5'd0;
      cnt_q      <= 2'd0;
      shadow_q   <= 32'd0;
      csum_q     <= 8'd0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      rd_addr_q  <= 5'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort && (state_q != S_IDLE)) begin
        // Abort beats a transfer on the same edge: the byte is dropped.
        state_q    <= S_IDLE;
        tx_valid_q <= 1'b0;
        tx_data_q  <= 8'd0;
        rd_addr_q  <= 5'd0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              state_q    <= S_HDR;
              tx_valid_q <= 1'b1;
              tx_data_q  <= HEADER;
              busy_q     <= 1'b1;
              csum_q     <= 8'd0;
              idx_q      <= 5'd0;
              cnt_q      <= 2'd0;
            end
          end
          S_HDR: begin
            if (xfer_d) begin
              state_q    <= S_LOAD;
              tx_valid_q <= 1'b0;
              idx_q      <= 5'd0;
              rd_addr_q  <= 5'd0;
            end
          end
          S_LOAD: begin
            // rd_addr already equals idx; capture the whole word once.
            shadow_q   <= bus.rd_data;
            tx_data_q  <= bus.rd_data[7:0];
            tx_valid_q <= 1'b1;
            cnt_q      <= 2'd0;
            state_q    <= S_DATA;
          end
          S_DATA: begin
            if (xfer_d) begin
              csum_q <= csum_d;
              if (cnt_q == 2'd3) begin
                if (idx_q == LAST_IDX) begin
                  state_q   <= S_CSUM;
                  tx_data_q <= csum_d;
                end else begin
                  state_q    <= S_LOAD;
                  tx_valid_q <= 1'b0;
                  idx_q      <= idx_q + 5'd1;
                  rd_addr_q  <= idx_q + 5'd1;
                end
              end else begin
                cnt_q     <= cnt_inc_d;
                tx_data_q <= next_byte_d;
              end
            end
          end
          S_CSUM: begin
            if (xfer_d) begin
              state_q    <= S_IDLE;
              tx_valid_q <= 1'b0;
              tx_data_q  <= 8'd0;
              rd_addr_q  <= 5'd0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end
          default: begin
            state_q    <= S_IDLE;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rd_addr  = rd_addr_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
